// File: rtl/i2c_bus_filter_pkg.sv
// Shared constants, bus-state encoding and the popcount helper used by the line filters.
package i2c_bus_filter_pkg;

    localparam int I2C_SYNC_STAGES = 2;
    localparam int I2C_FILTER_LEN  = 3;
    localparam int I2C_PRESCALE_W  = 14;
    localparam int I2C_TIMEOUT_W   = 16;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_BUSY = 1'b1
    } bus_state_t;

    // Only the low n bits of v are counted, so callers can zero-extend any window width.
    function automatic int popcount(input logic [31:0] v, input int n);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < n && v[i]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/i2c_bus_filter_if.sv
// Core-side view of the line conditioner: drive requests, runtime config, filtered levels and events.
interface i2c_bus_filter_if #(
    parameter int PRESCALE_W = 14,
    parameter int TIMEOUT_W  = 16
);
    logic                  scl_o;
    logic                  sda_o;
    logic                  filter_en;
    logic [PRESCALE_W-1:0] prescale;
    logic [TIMEOUT_W-1:0]  timeout;
    logic                  scl_i;
    logic                  sda_i;
    logic                  scl_rising;
    logic                  scl_falling;
    logic                  sta_det;
    logic                  rsta_det;
    logic                  sto_det;
    logic                  busy;
    logic                  bus_timeout;

    modport slave (
        input  scl_o, sda_o, filter_en, prescale, timeout,
        output scl_i, sda_i, scl_rising, scl_falling, sta_det, rsta_det, sto_det,
               busy, bus_timeout
    );

    modport master (
        output scl_o, sda_o, filter_en, prescale, timeout,
        input  scl_i, sda_i, scl_rising, scl_falling, sta_det, rsta_det, sto_det,
               busy, bus_timeout
    );
endinterface

// File: rtl/i2c_bus_filter_line_filter.sv
// One pad line: synchroniser, tick-sampled majority window (or bypass), then s/d history registers.
module i2c_line_filter
    import i2c_bus_filter_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_STAGES,
    parameter int FILTER_LEN  = I2C_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    input  logic tick,
    input  logic filter_en,
    output logic s,
    output logic d
);
    logic [SYNC_STAGES-1:0] sync;
    logic [FILTER_LEN-1:0]  window;
    logic                   majority;

    assign majority = popcount(32'(window), FILTER_LEN) > FILTER_LEN / 2;

    // Everything resets to 1 so an idle bus produces no edges when reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '1;
            window <= '1;
            s      <= 1'b1;
            d      <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pad};
            if (tick) window <= {window[FILTER_LEN-2:0], sync[SYNC_STAGES-1]};
            s <= filter_en ? majority : sync[SYNC_STAGES-1];
            d <= s;
        end
    end
endmodule

// File: rtl/i2c_bus_filter.sv
// I2C pad conditioner: open-drain drive, filtered SCL/SDA, START/STOP/edge detect,
// bus-busy tracking and SCL stuck-low timeout.
module i2c_bus_filter
    import i2c_bus_filter_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_STAGES,
    parameter int FILTER_LEN  = I2C_FILTER_LEN,
    parameter int PRESCALE_W  = I2C_PRESCALE_W,
    parameter int TIMEOUT_W   = I2C_TIMEOUT_W
) (
    input  logic            clk,
    input  logic            rst,
    inout  wire             scl,
    inout  wire             sda,
    i2c_bus_filter_if.slave bus
);
    logic                  tick;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  scl_s, scl_d, sda_s, sda_d;
    logic                  sta, sto;
    bus_state_t            state;
    logic [TIMEOUT_W-1:0]  to_cnt;
    logic [TIMEOUT_W-1:0]  to_next;
    logic                  to_pulse;

    // Pads are released while in reset so a reset mid-transfer frees the bus.
    assign scl = (bus.scl_o || rst) ? 1'bz : 1'b0;
    assign sda = (bus.sda_o || rst) ? 1'bz : 1'b0;

    assign tick = (pre_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pre_cnt <= '0;
        else     pre_cnt <= tick ? bus.prescale : pre_cnt - 1'b1;
    end

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
        .clk(clk), .rst(rst), .pad(scl), .tick(tick), .filter_en(bus.filter_en),
        .s(scl_s), .d(scl_d)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
        .clk(clk), .rst(rst), .pad(sda), .tick(tick), .filter_en(bus.filter_en),
        .s(sda_s), .d(sda_d)
    );

    assign sta = scl_d & sda_d & ~sda_s;
    assign sto = scl_d & ~sda_d & sda_s;

    assign bus.scl_i       = scl_d;
    assign bus.sda_i       = sda_d;
    assign bus.scl_rising  = ~scl_d & scl_s;
    assign bus.scl_falling = scl_d & ~scl_s;
    assign bus.sta_det     = sta;
    assign bus.sto_det     = sto;
    assign bus.rsta_det    = sta & bus.busy;
    assign bus.busy        = (state == BUS_BUSY);
    assign bus.bus_timeout = to_pulse;

    // START wins over a coincident timeout so a fresh transaction is never dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BUS_IDLE;
        end else begin
            case (state)
                BUS_IDLE: if (sta) state <= BUS_BUSY;
                BUS_BUSY: if (!sta && (sto || to_pulse)) state <= BUS_IDLE;
                default:  state <= BUS_IDLE;
            endcase
        end
    end

    assign to_next = to_cnt + 1'b1;

    // Counter saturates, so the equality match fires exactly once per low period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt   <= '0;
            to_pulse <= 1'b0;
        end else begin
            to_pulse <= 1'b0;
            if (scl_s || bus.timeout == '0) begin
                to_cnt <= '0;
            end else if (tick && to_cnt != '1) begin
                to_cnt   <= to_next;
                to_pulse <= (to_next == bus.timeout);
            end
        end
    end
endmodule
